// File: rtl/multicycle_control.sv
// Multicycle CPU control unit.
//
// Sequences FETCH -> DECODE -> EXEC/BRANCH -> MEM -> WB and drives the datapath
// selects and load enables for each step. Memory steps (FETCH, MEM) wait for mem_ack
// under a timeout. A timeout, or an illegal opcode, parks the unit in HALT until reset.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     instruction bits [31:26]: class = [5:4], code = [3:0]
//   beq_alu         ALU equality flag, used by branches
//   mem_ack         memory completion strobe, only looked at in FETCH and MEM
//   alu_selection   ALU operation select
//   alu_src_a       0 = PC, 1 = register A
//   alu_src_b       00 = register B, 01 = constant 4, 10 = sign-extended immediate
//   mem_req/mem_we  memory request / write enable
//   ir_write, pc_write, reg_write  datapath load enables
//   mem_to_reg      writeback mux select (1 = memory data)
//   pc_src          00 = ALU result, 01 = target register, 10 = jump field
//   halted          unit stopped on illegal opcode or bus error
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       beq_alu,
  input  logic       mem_ack,
  output logic [3:0] alu_selection,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       halted
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Value of the wait counter during the last cycle a memory step may wait.
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StBranch = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  // Cleared by reset: holds every output low until the first clock after release,
  // so the unit sits in FETCH without requesting memory while reset is applied.
  logic            started_q, started_d;

  logic [1:0] cls_q;
  logic [3:0] code_q;
  logic       is_load, is_store;

  assign cls_q    = op_q[5:4];
  assign code_q   = op_q[3:0];
  assign is_load  = (cls_q == 2'b10) && (code_q == 4'b0000);
  assign is_store = (cls_q == 2'b10) && (code_q == 4'b0001);

  function automatic logic alu_code_legal(input logic [3:0] code);
    unique case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b0111, 4'b1001, 4'b1100: alu_code_legal = 1'b1;
      default:                            alu_code_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      op_q      <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    op_d          = op_q;
    started_d     = 1'b1;
    alu_selection = 4'b0000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_src        = 2'b00;
    halted        = 1'b0;

    if (!started_q) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          mem_req       = 1'b1;
          alu_src_b     = 2'b01;
          alu_selection = 4'b0010;
          // An ack in the final wait cycle still completes the fetch.
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else if (cnt_q == CntLast) begin
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StDecode: begin
          // Precompute the branch target while the opcode is captured.
          alu_src_b     = 2'b10;
          alu_selection = 4'b0010;
          op_d          = opcode;
          unique case (opcode[5:4])
            2'b11:   state_d = StBranch;
            2'b10:   state_d = StExec;
            default: state_d = alu_code_legal(opcode[3:0]) ? StExec : StHalt;
          endcase
        end

        StExec: begin
          alu_src_a = 1'b1;
          unique case (cls_q)
            2'b00: begin
              alu_src_b     = 2'b00;
              alu_selection = code_q;
              state_d       = StWb;
            end
            2'b01: begin
              alu_src_b     = 2'b10;
              alu_selection = code_q;
              state_d       = StWb;
            end
            default: begin
              // Effective address for load/store.
              alu_src_b     = 2'b10;
              alu_selection = 4'b0010;
              state_d       = (is_load || is_store) ? StMem : StHalt;
            end
          endcase
        end

        StMem: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ack) begin
            state_d = is_store ? StFetch : StWb;
          end else if (cnt_q == CntLast) begin
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          state_d    = StFetch;
        end

        StBranch: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b00;
          alu_selection = 4'b0011;
          state_d       = StFetch;
          unique case (code_q)
            4'b0000: begin
              pc_write = beq_alu;
              pc_src   = 2'b01;
            end
            4'b0001: begin
              pc_write = ~beq_alu;
              pc_src   = 2'b01;
            end
            4'b0010: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            default: state_d = StHalt;
          endcase
        end

        StHalt: begin
          halted = 1'b1;
        end

        default: begin
          state_d = StHalt;
        end
      endcase
    end
  end

endmodule
